if_stage_fetch_unit: RTL

//  Instruction-fetch stage plus IF/ID pipeline register; feeds the decode stage and hazard unit.

---
 rtl/if_stage_fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register, req/ack memory handshake and freeze hold buffer.
// Optional stall counter port enabled by defining STALL_COUNTER_EN.
module if_stage_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
`ifdef STALL_COUNTER_EN
    ,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HELD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] hold_buf;
    logic [31:0] branch_target;

    assign imem_addr     = pc;
    assign pc_next       = pc + 32'd4;
    assign branch_target = branch_addr & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC & 32'hFFFF_FFFC;
            hold_buf    <= '0;
            imem_req    <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over freeze and ack; any returning word is dropped.
            state       <= S_FETCH;
            pc          <= branch_target;
            hold_buf    <= '0;
            imem_req    <= 1'b1;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack && !freeze) begin
                        pc          <= pc_next;
                        if_id_pc    <= pc_next;
                        if_id_instr <= imem_rdata;
                        if_id_valid <= 1'b1;
                    end else if (imem_ack) begin
                        hold_buf <= imem_rdata;
                        state    <= S_HELD;
                        imem_req <= 1'b0;
                    end else if (!freeze) begin
                        if_id_pc    <= '0;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end
                S_HELD: begin
                    if (!freeze) begin
                        pc          <= pc_next;
                        if_id_pc    <= pc_next;
                        if_id_instr <= hold_buf;
                        if_id_valid <= 1'b1;
                        state       <= S_FETCH;
                        imem_req    <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (freeze && !branch_taken && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
